// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Wide all-ones anode pattern; users slice it down to their digit count.
    localparam int                    MAX_DIGITS = 32;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF  = '1;

endpackage

// File: rtl/seg_lz_mask.sv
// Per-digit blanking mask: non-BCD nibbles, plus leading zeros when blank_lz is set.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module seg_lz_mask
    import seg_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] displayed,
    input  logic                blank_lz,
    output logic [DIGITS-1:0]   suppress
);

    logic       zero_run;
    logic [3:0] nib;

    // Walk from the most significant digit down; zero_run stays set while every
    // nibble seen so far is zero. Digit 0 is always exempt from zero blanking.
    always_comb begin
        suppress = '0;
        zero_run = 1'b1;
        nib      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib         = displayed[4*i +: 4];
            zero_run    = zero_run && (nib == 4'd0);
            suppress[i] = (nib > BCD_MAX) || (blank_lz && (i != 0) && zero_run);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with per-slot blanking and frame-boundary value commit.
// Latency: outputs registered; a load is displayed from the frame after the next commit edge.
// Backpressure: none; loads always accepted, latest value wins. SEG_SCAN_BRIGHTNESS_EN adds bright.
module seg_scan_ctrl #(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLANK_TICKS     = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] value,
    input  logic                load,
    input  logic                blank_lz,
`ifdef SEG_SCAN_BRIGHTNESS_EN
    input  logic [3:0]          bright,
`endif
    output logic [3:0]          seg_num,
    output logic                seg_en,
    output logic [DIGITS-1:0]   an,
    output logic                busy,
    output logic                frame_start
);

    import seg_pkg::*;

    localparam int SHOW_TICKS = TICKS_PER_DIGIT - BLANK_TICKS;
    localparam int TW         = $clog2(TICKS_PER_DIGIT + 1);
    localparam int IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TW-1:0]     BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [TW-1:0]     SHOW_LAST  = TW'(SHOW_TICKS - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF     = ANODE_OFF[DIGITS-1:0];
    localparam logic [DIGITS-1:0] AN_ONE     = {{(DIGITS-1){1'b0}}, 1'b1};

    scan_state_t         state, state_nxt;
    logic [TW-1:0]       tick, tick_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic                wrap;
    logic [4*DIGITS-1:0] displayed, pending;
    logic [DIGITS-1:0]   suppress;
    logic                lit;
    logic [DIGITS-1:0]   an_nxt;
    logic [3:0]          seg_num_nxt;
    logic                seg_en_nxt;

    seg_lz_mask #(
        .DIGITS (DIGITS)
    ) u_lz_mask (
        .displayed (displayed),
        .blank_lz  (blank_lz),
        .suppress  (suppress)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BLANK;
            tick  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            tick  <= tick_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick + 1'b1;
        idx_nxt   = idx;
        wrap      = 1'b0;
        case (state)
            BLANK: begin
                if (tick == BLANK_LAST) begin
                    state_nxt = SHOW;
                    tick_nxt  = '0;
                end
            end
            SHOW: begin
                if (tick == SHOW_LAST) begin
                    state_nxt = BLANK;
                    tick_nxt  = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt = '0;
                        wrap    = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = BLANK;
                tick_nxt  = '0;
            end
        endcase
    end

`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [TW-1:0] on_ticks, on_ticks_nxt;

    // On-time is latched on the edge that enters SHOW so a slot never changes
    // duty cycle half-way through.
    always_comb begin
        on_ticks_nxt = on_ticks;
        if (state == BLANK && state_nxt == SHOW)
            on_ticks_nxt = TW'((SHOW_TICKS * (int'(bright) + 1)) >> 4);
        lit = (tick_nxt < on_ticks_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) on_ticks <= '0;
        else     on_ticks <= on_ticks_nxt;
    end
`else
    always_comb lit = 1'b1;
`endif

    // Outputs are computed from the next state so the registered pins line up
    // with the state they describe.
    always_comb begin
        an_nxt      = AN_OFF;
        seg_num_nxt = 4'd0;
        seg_en_nxt  = 1'b0;
        if (state_nxt == SHOW && lit) begin
            an_nxt      = ~(AN_ONE << idx_nxt);
            seg_num_nxt = displayed[4*idx_nxt +: 4];
            seg_en_nxt  = !suppress[idx_nxt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            displayed   <= '0;
            pending     <= '0;
            busy        <= 1'b0;
            an          <= AN_OFF;
            seg_num     <= 4'd0;
            seg_en      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            seg_num     <= seg_num_nxt;
            seg_en      <= seg_en_nxt;
            frame_start <= wrap;
            if (wrap && busy)
                displayed <= pending;
            // A load on the commit edge refills pending while the old value commits.
            if (load) begin
                pending <= value;
                busy    <= 1'b1;
            end else if (wrap && busy) begin
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed scoreboard bench for seg_scan_ctrl with DIGITS=4, TICKS_PER_DIGIT=8, BLANK_TICKS=2.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  bright;
    logic [3:0]  seg_num;
    logic        seg_en;
    logic [3:0]  an;
    logic        busy;
    logic        frame_start;

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;
    int on_exp  = 6;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic       en;
        logic [3:0] num;
        bit         chk_num;
        logic       busy;
        logic       fs;
    } exp_t;

    exp_t q[$];

    seg_scan_ctrl #(
        .DIGITS          (4),
        .TICKS_PER_DIGIT (8),
        .BLANK_TICKS     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .load        (load),
        .blank_lz    (blank_lz),
`ifdef SEG_SCAN_BRIGHTNESS_EN
        .bright      (bright),
`endif
        .seg_num     (seg_num),
        .seg_en      (seg_en),
        .an          (an),
        .busy        (busy),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d required end", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic bsy(input int c, input int on, input int off);
        return (c >= on) && (c < off);
    endfunction

    task automatic push(input int c, input logic [3:0] a, input logic e, input logic [3:0] n,
                        input bit cn, input logic b, input logic f);
        exp_t x;
        x.cyc = c; x.an = a; x.en = e; x.num = n; x.chk_num = cn; x.busy = b; x.fs = f;
        q.push_back(x);
    endtask

    // Expected outputs for one frame: blank edges, first/last lit SHOW cycle,
    // and the dark tail when brightness shortens the on-time.
    task automatic push_frame(input int base, input logic [15:0] disp, input logic [3:0] en_mask,
                              input int b_on, input int b_off, input logic fs0,
                              input int on, input int ndig);
        logic [3:0] one;
        logic [3:0] anl;
        logic [3:0] nib;
        int         s;
        one = 4'b0001;
        for (int d = 0; d < ndig; d++) begin
            s   = base + 8 * d;
            anl = ~(one << d);
            nib = disp[4*d +: 4];
            push(s,          4'hF, 1'b0,       4'h0, 0, bsy(s, b_on, b_off),          (d == 0) ? fs0 : 1'b0);
            push(s + 1,      4'hF, 1'b0,       4'h0, 0, bsy(s + 1, b_on, b_off),      1'b0);
            push(s + 2,      anl,  en_mask[d], nib,  1, bsy(s + 2, b_on, b_off),      1'b0);
            push(s + 1 + on, anl,  en_mask[d], nib,  1, bsy(s + 1 + on, b_on, b_off), 1'b0);
            if (on < 6) begin
                push(s + 2 + on, 4'hF, 1'b0, 4'h0, 0, bsy(s + 2 + on, b_on, b_off), 1'b0);
                push(s + 7,      4'hF, 1'b0, 4'h0, 0, bsy(s + 7, b_on, b_off),      1'b0);
            end
        end
    endtask

    task automatic drain();
        exp_t x;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            x = q.pop_front();
            if (x.cyc < cyc) begin
                chk($sformatf("c%0d stale", x.cyc), 16'(cyc), 16'(x.cyc));
            end else begin
                chk($sformatf("c%0d an", cyc),          16'(an),          16'(x.an));
                chk($sformatf("c%0d seg_en", cyc),      16'(seg_en),      16'(x.en));
                chk($sformatf("c%0d busy", cyc),        16'(busy),        16'(x.busy));
                chk($sformatf("c%0d frame_start", cyc), 16'(frame_start), 16'(x.fs));
                if (x.chk_num)
                    chk($sformatf("c%0d seg_num", cyc), 16'(seg_num), 16'(x.num));
            end
        end
    endtask

    task automatic run_to(input int c);
        drain();
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
            drain();
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        run_to(cyc + 1);
        load  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        value    = 16'h0;
        load     = 1'b0;
        blank_lz = 1'b0;
        bright   = 4'd15;
        repeat (3) @(negedge clk);
        chk("rst an",          16'(an),          16'hF);
        chk("rst seg_en",      16'(seg_en),      16'h0);
        chk("rst seg_num",     16'(seg_num),     16'h0);
        chk("rst busy",        16'(busy),        16'h0);
        chk("rst frame_start", 16'(frame_start), 16'h0);
        rst = 1'b0;
        cyc = 0;

        // Idle frame of zeros, then a load mid-frame that must wait for the commit.
        push_frame(0,   16'h0000, 4'hF, 11,  32,  1'b0, 6, 4);
        run_to(10);
        do_load(16'h1234);
        push_frame(32,  16'h1234, 4'hF, 41,  64,  1'b1, 6, 4);
        run_to(40);
        blank_lz = 1'b1;
        do_load(16'h0070);
        push_frame(64,  16'h0070, 4'b0011, 71,  96,  1'b1, 6, 4);
        run_to(70);
        do_load(16'h0000);
        push_frame(96,  16'h0000, 4'b0001, 101, 128, 1'b1, 6, 4);
        run_to(100);
        do_load(16'h00A5);
        run_to(128);
        blank_lz = 1'b0;
        push_frame(128, 16'h00A5, 4'b1101, 141, 160, 1'b1, 6, 4);
        run_to(140);
        do_load(16'h1111);
        run_to(150);
        do_load(16'h2222);
        push_frame(160, 16'h2222, 4'hF, 192, 224, 1'b1, 6, 4);
        run_to(191);
        do_load(16'h3333);
        push_frame(192, 16'h2222, 4'hF, 192, 224, 1'b1, 6, 4);
        push_frame(224, 16'h3333, 4'hF, 231, 9999, 1'b1, 6, 1);
        run_to(230);
        do_load(16'h4444);
        run_to(235);
        chk("pre-rst an",      16'(an),      16'hD);
        chk("pre-rst seg_num", 16'(seg_num), 16'h3);
        chk("pre-rst busy",    16'(busy),    16'h1);

        // Asynchronous reset in the middle of a SHOW slot.
        #2;
        rst = 1'b1;
        #1;
        chk("async-rst an",          16'(an),          16'hF);
        chk("async-rst seg_en",      16'(seg_en),      16'h0);
        chk("async-rst busy",        16'(busy),        16'h0);
        chk("async-rst frame_start", 16'(frame_start), 16'h0);
        @(negedge clk);
`ifdef SEG_SCAN_BRIGHTNESS_EN
        bright = 4'd7;
        on_exp = 3;
`endif
        rst = 1'b0;
        cyc = 0;
        push_frame(0,  16'h0000, 4'hF, -1, -1, 1'b0, on_exp, 4);
        push_frame(32, 16'h0000, 4'hF, -1, -1, 1'b1, 6, 4);
        run_to(33);
        bright = 4'd15;
        run_to(64);
        chk("queue empty", 16'(q.size()), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexes a multi-digit BCD value onto one shared seven-segment decoder and a common-anode digit bank for the countdown display. The block sequences digits, drives the decoder's enable and num inputs, and drives the active-low anode selects. It inserts a blanking gap between digits to suppress ghosting. New values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
DIGITS, 4, number of multiplexed digits (≥2); digit 0 is least significant.
TICKS_PER_DIGIT, 50000, clk cycles per digit slot, including the blank gap.
BLANK_TICKS, 500, cycles at the start of each slot with all anodes off; legal range is 1 ≤ BLANK_TICKS < TICKS_PER_DIGIT.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  asynchronous, active-high reset.
value  in  4*DIGITS  BCD digits; nibble i is digit i.
load  in  1  single-cycle strobe; captures value into the pending register.
blank_lz  in  1  when 1, leading zeros are suppressed.
seg_num  out  4  BCD code to the decoder's num input.
seg_en  out  1  decoder enable; 0 blanks all segments.
an  out  DIGITS  anode selects, active low, at most one bit low.
busy  out  1  a pending value is waiting for commit.
frame_start  out  1  one-cycle pulse at each frame commit point.

Behaviour:
- All outputs are registered.
- Reset values: an all 1s, seg_en 0, seg_num 0, busy 0, frame_start 0; digit index 0, state BLANK, tick counter 0, displayed and pending registers 0.
- Reset takes effect immediately, including mid-slot.
- FSM states and transitions:
  - BLANK: lasts BLANK_TICKS cycles; an all 1s, seg_en 0. Then go to SHOW.
  - SHOW: lasts TICKS_PER_DIGIT−BLANK_TICKS cycles for digit idx. Then increment idx and go to BLANK.
- Wrap-around: after SHOW of idx DIGITS−1, idx returns to 0. On that same edge frame_start is 1 for one cycle, and if busy, pending is copied to displayed and busy clears.
- Frame length is DIGITS*TICKS_PER_DIGIT cycles.
- SHOW outputs: an = ~(1<<idx), seg_num = displayed nibble idx, seg_en = 1 unless that digit is suppressed.
- A digit is suppressed in either case:
  - its nibble is greater than 9 (the decoder only covers 0–9);
  - blank_lz=1, idx≠0, and every nibble from idx up to DIGITS−1 is 0.
- Digit 0 is never zero-suppressed.
- On a load cycle: pending ← value, busy ← 1.
- Multiple loads before commit: the latest value wins.
- load on the commit edge: that value goes to pending and busy stays 1; the previously pending value is what gets committed.
- blank_lz is sampled live; it is not buffered.

Optional Feature:
SEG_SCAN_BRIGHTNESS_EN:
- Defined: adds input port bright [3:0]. During SHOW, an and seg_en are active only while the SHOW tick count < ((TICKS_PER_DIGIT−BLANK_TICKS)*(bright+1))>>4. For the rest of the SHOW phase, outputs are as in BLANK. bright=15 gives full on-time. bright is sampled at the start of each SHOW phase.
- Undefined: no bright port; full on-time.
- Slot and frame timing are identical in both builds.

Decomposition:
- Package seg_pkg holds:
  - the FSM state enum (BLANK, SHOW);
  - BCD_MAX = 9;
  - ANODE_OFF helper/constant for an all-1s value of width DIGITS.
- One sub-module, seg_lz_mask: purely combinational. Maps displayed value and blank_lz to a DIGITS-bit suppress mask (covers both leading-zero and >9 suppression).
- Counters and FSM remain in seg_scan_ctrl.

Test Plan (all with DIGITS=4, TICKS_PER_DIGIT=8, BLANK_TICKS=2, frame = 32 cycles):
1. Reset released, displayed=0 -> an=4'b1111, seg_en=0 for 2 cycles; then an=4'b1110, seg_num=0, seg_en=1 for 6 cycles; an steps 1101, 1011, 0111.
2. load value=16'h1234 at cycle 10 -> busy=1 and outputs unchanged until frame_start (cycle 32). Next frame digits 0..3 show 4, 3, 2, 1; busy=0.
3. blank_lz=1, value=16'h0070 -> digits 3 and 2 have seg_en=0; digit 1 shows 7; digit 0 shows 0. With value=16'h0000, only digit 0 is enabled, showing 0.
4. value=16'h00A5 -> digit 1 slot has an low but seg_en=0; digit 0 shows 5.
5. Two loads in one frame (16'h1111 then 16'h2222), plus rst pulsed mid-SHOW in a later run -> 2222 is committed. rst asynchronously forces an=1111, seg_en=0, busy=0 and clears displayed.
6. SEG_SCAN_BRIGHTNESS_EN, bright=7 -> each SHOW has seg_en=1 for 3 cycles (6*8>>4), then 3 cycles off. bright=15 -> 6 cycles on.
